// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-addressed memory port between instruction fetch and data load/store
// Ports: clk, rst (sync, active high); fetch side f_req/f_addr/f_ack;
//   data side d_req/d_we/d_size/d_unsigned/d_addr/d_wdata/d_ack/d_misalign;
//   rdata (last fetch/load result), busy; memory side mem_addr/mem_wdata/mem_write/mem_rdata.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word data accesses.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_misalign,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_WAIT, WR, ACK} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic is_d, is_d_n, uns, uns_n;
  logic [1:0] size, size_n, lo, lo_n;
  logic [15:0] wdata, wdata_n;
  logic [31:0] mem_wdata_n, rdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic mem_write_n, f_ack_n, d_ack_n, mis_n, trap, d_word;
  assign d_word = d_size[0] == d_size[1];
`ifdef MISALIGN_TRAP_EN
  assign trap = (d_size == 2'b01 && d_addr[0]) || (d_word && d_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif
  function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] a, logic [1:0] sz, logic u);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return sz == 2'b10 ? {{24{b[7] & ~u}}, b} : sz == 2'b01 ? {{16{h[15] & ~u}}, h} : w;
  endfunction
  // only byte/half stores reach the merge, so anything not a byte is a half
  function automatic logic [31:0] merge(logic [31:0] w, logic [15:0] d, logic [1:0] a, logic [1:0] sz);
    logic [31:0] r;
    r = w;
    if (sz == 2'b10) r[{a, 3'b000} +: 8] = d[7:0];
    else r[{a[1], 4'b0000} +: 16] = d;
    return r;
  endfunction
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    is_d_n = is_d;
    uns_n = uns;
    size_n = size;
    lo_n = lo;
    wdata_n = wdata;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_write_n = 1'b0;
    rdata_n = rdata;
    f_ack_n = 1'b0;
    d_ack_n = 1'b0;
    mis_n = 1'b0;
    case (state)
      IDLE: if (d_req || f_req) begin
        // data has fixed priority; fetch keeps its request held and is served next IDLE
        is_d_n = d_req;
        uns_n = d_unsigned;
        size_n = d_size;
        lo_n = d_addr[1:0];
        wdata_n = d_wdata[15:0];
        mem_addr_n = (d_req ? d_addr : f_addr) & ~ADDR_W'(3);
        cnt_n = 3'(MEM_LAT);
        if (d_req && trap) begin
          state_n = ACK;
          d_ack_n = 1'b1;
          mis_n = 1'b1;
          rdata_n = '0;
        end else if (!d_req || !d_we) state_n = RD_WAIT;
        else if (d_word) begin
          state_n = WR;
          mem_wdata_n = d_wdata;
          mem_write_n = 1'b1;
        end else state_n = RMW_WAIT;
      end
      RD_WAIT: if (cnt == 3'd0) begin
        state_n = ACK;
        rdata_n = is_d ? extract(mem_rdata, lo, size, uns) : mem_rdata;
        f_ack_n = !is_d;
        d_ack_n = is_d;
      end else cnt_n = cnt - 3'd1;
      RMW_WAIT: if (cnt == 3'd0) begin
        state_n = WR;
        mem_wdata_n = merge(mem_rdata, wdata, lo, size);
        mem_write_n = 1'b1;
      end else cnt_n = cnt - 3'd1;
      WR: begin
        state_n = ACK;
        d_ack_n = 1'b1;
      end
      ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      is_d <= 1'b0;
      uns <= 1'b0;
      size <= '0;
      lo <= '0;
      wdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      rdata <= '0;
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      d_misalign <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      is_d <= is_d_n;
      uns <= uns_n;
      size <= size_n;
      lo <= lo_n;
      wdata <= wdata_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_write <= mem_write_n;
      rdata <= rdata_n;
      f_ack <= f_ack_n;
      d_ack <= d_ack_n;
      d_misalign <= mis_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level model checked every cycle
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int ADDR_W = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [1:0] d_size = 2'b00;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic f_ack, d_ack, d_misalign, busy, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_misalign(d_misalign),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_run = 0, n_fail = 0, wr_cnt = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask
  task automatic chkb(input string name, input logic got, input logic exp);
    chk(name, {31'd0, got}, {31'd0, exp});
  endtask
  // memory: data is only valid once the read address has been stable for MEM_LAT cycles
  logic [31:0] sim_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_a = '0;
  int age = 0;
  assign mem_rdata = (age >= MEM_LAT) ? sim_mem[last_a[5:2]] : 32'hDEADBEEF;
  always @(posedge clk) if (mem_write === 1'b1) sim_mem[mem_addr[5:2]] = mem_wdata;
  always @(negedge clk) begin
    if (mem_write === 1'b1 || mem_addr !== last_a) begin
      age = 0;
      last_a = mem_addr;
    end else age = age + 1;
  end
  task automatic poke(input int i, input logic [31:0] v);
    sim_mem[i] = v;
    ref_mem[i] = v;
  endtask
  // transaction-level model
  bit live = 0, act = 0, rd_txn = 0, trap = 0, is_d = 0, m_addr_ok = 0;
  int free_at = 0, g_cyc = 0, a_cyc = 0, w_cyc = -1, w_idx = 0;
  logic [31:0] exp_rd = '0, m_rdata = '0, m_addr = '0, w_data = '0;
  task automatic grant();
    logic [31:0] w, v, mask, sh;
    logic [1:0] lo;
    bit half, bsz, wsz;
    act = 1; g_cyc = cyc; is_d = d_req; trap = 0; rd_txn = 1; w_cyc = -1;
    if (d_req) begin
      lo = d_addr[1:0];
      w = ref_mem[d_addr[5:2]];
      half = d_size == 2'b01;
      bsz = d_size == 2'b10;
      wsz = !half && !bsz;
`ifdef MISALIGN_TRAP_EN
      trap = (half && lo[0]) || (wsz && lo != 2'b00);
`endif
      m_addr = {d_addr[31:2], 2'b00};
      if (trap) begin
        a_cyc = cyc + 1;
        exp_rd = '0;
      end else if (!d_we) begin
        a_cyc = cyc + MEM_LAT + 2;
        if (bsz) begin
          v = (w >> (8 * lo)) & 32'hFF;
          if (!d_unsigned && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (half) begin
          v = (w >> (16 * (lo / 2))) & 32'hFFFF;
          if (!d_unsigned && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else v = w;
        exp_rd = v;
      end else begin
        rd_txn = 0;
        w_idx = int'(d_addr[5:2]);
        if (wsz) begin
          a_cyc = cyc + 2;
          w_cyc = cyc + 1;
          w_data = d_wdata;
        end else begin
          sh = bsz ? 8 * lo : 16 * (lo / 2);
          mask = (bsz ? 32'hFF : 32'hFFFF) << sh;
          w_data = (w & ~mask) | ((d_wdata << sh) & mask);
          a_cyc = cyc + MEM_LAT + 3;
          w_cyc = a_cyc - 1;
        end
      end
    end else begin
      m_addr = {f_addr[31:2], 2'b00};
      a_cyc = cyc + MEM_LAT + 2;
      exp_rd = ref_mem[f_addr[5:2]];
    end
    m_addr_ok = !trap;
    free_at = a_cyc + 1;
  endtask
  always @(negedge clk) begin
    if (live) begin
      if (act && rd_txn && cyc == a_cyc) m_rdata = exp_rd;
      chkb("f_ack", f_ack, act && !is_d && cyc == a_cyc);
      chkb("d_ack", d_ack, act && is_d && cyc == a_cyc);
      chkb("d_misalign", d_misalign, act && trap && cyc == a_cyc);
      chkb("mem_write", mem_write, act && cyc == w_cyc);
      chkb("busy", busy, act && cyc > g_cyc);
      chk("rdata", rdata, m_rdata);
      if (m_addr_ok) chk("mem_addr", mem_addr, m_addr);
      if (act && cyc == w_cyc) begin
        chk("mem_wdata", mem_wdata, w_data);
        ref_mem[w_idx] = w_data;
      end
      if (mem_write === 1'b1) wr_cnt++;
      if (act && cyc == a_cyc) act = 0;
    end
    if (rst) begin
      live = 1; act = 0; free_at = cyc + 1;
      m_rdata = '0; m_addr = '0; m_addr_ok = 1;
    end else if (live && !act && cyc >= free_at && (d_req || f_req)) grant();
  end
  task automatic wait_ack(input bit d, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (d ? d_ack : f_ack) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_run++;
      n_fail++;
      $display("FAIL ack_timeout: got no %s ack, expected one within 40 cycles", d ? "d" : "f");
    end
  endtask
  task automatic run_fetch(input logic [31:0] a, output int lat, output logic [31:0] rd);
    int c0, at;
    @(posedge clk);
    #1;
    f_addr = a; f_req = 1'b1; c0 = cyc;
    wait_ack(1'b0, at);
    rd = rdata; f_req = 1'b0; lat = at - c0;
  endtask
  task automatic run_data(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic mis);
    int c0, at;
    @(posedge clk);
    #1;
    d_we = we; d_size = sz; d_unsigned = u; d_addr = a; d_wdata = wd; d_req = 1'b1; c0 = cyc;
    wait_ack(1'b1, at);
    rd = rdata; mis = d_misalign; d_req = 1'b0; lat = at - c0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us");
    $fatal(1);
  end
  initial begin
    int lat, c0, at, w0;
    logic [31:0] rd, a1;
    logic mis;
    for (int i = 0; i < 16; i++) poke(i, 32'h10000000 + i);
    poke(1, 32'hCAFE0004);
    poke(2, 32'h20080005);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 32'({f_ack, d_ack, d_misalign, mem_write, busy}), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    run_fetch(32'h8, lat, rd);
    chk("fetch_lat", lat, 4);
    chk("fetch_rdata", rd, 32'h20080005);
    chk("fetch_no_write", wr_cnt, 0);
    poke(4, 32'h11223344);
    w0 = wr_cnt;
    run_data(1'b1, 2'b10, 1'b0, 32'h13, 32'h000000AB, lat, rd, mis);
    chk("sb_lat", lat, 5);
    chk("sb_writes", wr_cnt - w0, 1);
    chk("sb_mem", sim_mem[4], 32'hAB223344);
    poke(4, 32'h0080FF00);
    run_data(1'b0, 2'b10, 1'b1, 32'h12, 32'h0, lat, rd, mis);
    chk("lbu_lat", lat, 4);
    chk("lbu", rd, 32'h00000080);
    run_data(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat, rd, mis);
    chk("lb", rd, 32'hFFFFFF80);
    run_data(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, mis);
    chk("lh", rd, 32'hFFFFFF00);
    run_data(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, mis);
    chk("lhu_hi", rd, 32'h00000080);
    run_data(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, mis);
    chk("lw_size3", rd, 32'h0080FF00);
    @(posedge clk);
    #1;
    d_we = 1'b0; d_size = 2'b00; d_addr = 32'h10; f_addr = 32'h8; d_req = 1'b1; f_req = 1'b1; c0 = cyc;
    wait_ack(1'b1, at);
    rd = rdata; a1 = mem_addr; d_req = 1'b0;
    chk("prio_d_lat", at - c0, 4);
    chk("prio_d_rdata", rd, 32'h0080FF00);
    chk("prio_d_addr", a1, 32'h10);
    wait_ack(1'b0, at);
    rd = rdata; a1 = mem_addr; f_req = 1'b0;
    chk("prio_f_lat", at - c0, 9);
    chk("prio_f_rdata", rd, 32'h20080005);
    chk("prio_f_addr", a1, 32'h8);
    run_data(1'b1, 2'b00, 1'b0, 32'h14, 32'hDEAD0001, lat, rd, mis);
    chk("sw_lat", lat, 2);
    run_data(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, lat, rd, mis);
    chk("sw_readback", rd, 32'hDEAD0001);
    run_data(1'b1, 2'b01, 1'b0, 32'h16, 32'h5555BEEF, lat, rd, mis);
    chk("sh_lat", lat, 5);
    run_data(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, lat, rd, mis);
    chk("sh_readback", rd, 32'hBEEF0001);
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    d_we = 1'b1; d_size = 2'b10; d_addr = 32'h10; d_wdata = 32'h77; d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chkb("rmw_busy", busy, 1'b1);
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_flags", 32'({f_ack, d_ack, d_misalign, mem_write, busy}), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_writes", wr_cnt - w0, 0);
    chk("rst_mid_mem", sim_mem[4], 32'h0080FF00);
    run_fetch(32'h8, lat, rd);
    chk("rst_fetch_lat", lat, 4);
    chk("rst_fetch_rdata", rd, 32'h20080005);
    w0 = wr_cnt;
    run_data(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, lat, rd, mis);
`ifdef MISALIGN_TRAP_EN
    chk("mis_w_lat", lat, 1);
    chkb("mis_w_flag", mis, 1'b1);
    chk("mis_w_rdata", rd, 32'h0);
    run_data(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, rd, mis);
    chk("mis_h_lat", lat, 1);
    chkb("mis_h_flag", mis, 1'b1);
    chk("mis_h_rdata", rd, 32'h0);
`else
    chk("mis_w_lat", lat, 4);
    chkb("mis_w_flag", mis, 1'b0);
    chk("mis_w_rdata", rd, 32'hCAFE0004);
    run_data(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, rd, mis);
    chk("mis_h_lat", lat, 4);
    chkb("mis_h_flag", mis, 1'b0);
    chk("mis_h_rdata", rd, 32'h0000FF00);
`endif
    chk("mis_writes", wr_cnt - w0, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between two requesters: instruction fetch and data load/store.
- Owns memory wait-state timing, so the main control FSM no longer counts read-latency states itself.
- Performs lane extraction and extension for byte/half loads.
- Performs read-modify-write for byte/half stores.
- Sits between the control unit, the datapath, and the synchronous word-addressed memory.

Parameters:
- MEM_LAT, 2, cycles from a stable read address (mem_write=0) to valid mem_rdata; legal range 1..7.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- f_req  in  1  fetch request; held until f_ack.
- f_addr  in  ADDR_W  fetch address; word access, low 2 bits ignored.
- f_ack  out  1  one-cycle pulse; rdata is valid in the same cycle.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 = word, 01 = half, 10 = byte; 11 is treated as word.
- d_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data; the value sits right-aligned.
- d_ack  out  1  one-cycle pulse.
- d_misalign  out  1  see Optional Feature; constant 0 when the feature is compiled out.
- rdata  out  32  load/fetch result; holds its value until the next ack.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  ADDR_W  word-aligned memory address; bits [1:0] are always 0.
- mem_wdata  out  32  memory write data.
- mem_write  out  1  memory write strobe; writes at the clock edge.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset: on a rising clk with rst=1, the FSM goes to IDLE. f_ack, d_ack, d_misalign, mem_write, busy are 0. mem_addr, mem_wdata, rdata are 0. The latency counter is 0.
- Reset mid-transaction: any in-flight access is abandoned and no ack is issued. If reset lands in the same cycle as a write, mem_write is forced to 0.
- All outputs are registered.
- States: IDLE, RD_WAIT, RMW_WAIT, WR, ACK.
- IDLE arbitration: d_req has fixed priority over f_req. If both are high, data is granted and fetch waits, with f_req still held. On grant, the FSM latches the requester id, address, size, unsigned flag and wdata. It drives mem_addr = {addr[ADDR_W-1:2],2'b00} and loads counter = MEM_LAT.
- Grant transitions from IDLE:
  - Fetch or load -> RD_WAIT.
  - Word store -> WR.
  - Byte/half store -> RMW_WAIT.
- RD_WAIT: decrement the counter; at 0 go to ACK.
  - Capture rdata from mem_rdata on that edge.
  - Fetch: the full word.
  - Load: the lane selected by addr[1:0], little-endian (byte lane n = bits 8n+7:8n; half lane = bits 16*addr[1]+15). Sign- or zero-extend per d_unsigned.
- RMW_WAIT: same count. At 0, merge the low 8/16 bits of wdata into the addressed lane of mem_rdata, load mem_wdata, assert mem_write, go to WR.
- WR:
  - Word store: mem_wdata = wdata and mem_write = 1 for exactly one cycle.
  - RMW: mem_write = 1 for exactly one cycle.
  - Then go to ACK, with mem_write deasserted.
- ACK: pulse the acknowledgement of the latched requester for one cycle, then go to IDLE. Re-arbitration happens in IDLE on the next cycle, so the minimum gap between grants is 1 IDLE cycle.
- Requester latency, from the IDLE cycle that sampled req to the ack cycle:
  - Read: MEM_LAT+2.
  - Word store: 2.
  - Sub-word store: MEM_LAT+3.
- Requester inputs may change after ack. The block uses only latched copies.
- Starvation: fetch is only ever delayed by one data transaction per IDLE, because the control unit holds d_req only while executing that instruction.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a data access with half and addr[0]=1, or word and addr[1:0]!=0, performs no memory access. In the ACK state reached directly from IDLE (latency 1), d_ack=1, d_misalign=1, rdata=0.
- Undefined: offending low bits are ignored (half uses addr[1]; word uses addr[1:0]=0). d_misalign is tied to 0.

Test Plan:
- Reset, MEM_LAT=2, f_req, f_addr=0x8, memory word 2 = 0x20080005 -> f_ack 4 cycles after the sampling IDLE, rdata = 0x20080005, mem_write never 1.
- f_req and d_req (load word 0x10) rise together -> d_ack first, f_ack served afterward, mem_addr sequence 0x10 then the fetch address.
- Byte store 0xAB to addr 0x13 over 0x11223344 -> exactly one write of 0xAB223344 to 0x10, d_ack 5 cycles after grant.
- Load byte 0x12 over 0x0080FF00: unsigned -> rdata 0x00000080; signed -> 0xFFFFFF80; half signed at 0x10 -> 0xFFFFFF00.
- rst asserted during RMW_WAIT -> no mem_write, no ack, all outputs 0 next cycle, next fetch served normally.
- With MISALIGN_TRAP_EN, word load at 0x6 -> d_ack and d_misalign together, latency 1, rdata 0, mem_write 0. Without the macro -> word 0x4 is returned.
